xy_point_reader: RTL and testbench

XY_POINT_READER -- requirements
Module: xy_point_reader

---
 rtl/xy_pkg.sv | 6 +
 rtl/xy_point_reader.sv | 88 ++++++++
 tb/tb_xy_point_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/xy_pkg.sv
// xy_pkg: shared widths and reader FSM encoding for the X/Y coordinate M10K pair.
package xy_pkg;
    localparam int XY_ADDR_W = 8;
    localparam int XY_DATA_W = 32;
    typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, FIN} xy_state_t;
endpackage

// File: rtl/xy_point_reader.sv
// xy_point_reader: streams the stored X/Y point list out of the M10K pair as valid/ready points.
module xy_point_reader
    import xy_pkg::*;
#(
    parameter int ADDR_W = XY_ADDR_W,
    parameter int DATA_W = XY_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        arr_size,
    output logic [ADDR_W-1:0] x_read_addr,
    output logic [ADDR_W-1:0] y_read_addr,
    input  logic [DATA_W-1:0] x_read_data,
    input  logic [DATA_W-1:0] y_read_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [DATA_W-1:0] pt_x,
    output logic [DATA_W-1:0] pt_y,
    output logic [7:0]        pt_index,
    output logic              pt_last,
    output logic              busy,
    output logic              done
);
    xy_state_t         state_q;
    logic [7:0]        size_q, idx_q, pt_index_q;
    logic [DATA_W-1:0] pt_x_q, pt_y_q;
    logic              pt_valid_q, pt_last_q, busy_q, done_q;

    // idx_q is itself a register and only changes while the address is not being sampled
    assign x_read_addr = ADDR_W'(idx_q);
    assign y_read_addr = ADDR_W'(idx_q);
    assign pt_valid    = pt_valid_q;
    assign pt_x        = pt_x_q;
    assign pt_y        = pt_y_q;
    assign pt_index    = pt_index_q;
    assign pt_last     = pt_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            size_q     <= '0;
            idx_q      <= '0;
            pt_index_q <= '0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
            pt_valid_q <= 1'b0;
            pt_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    size_q  <= arr_size;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= (arr_size == 8'd0) ? FIN : READ;
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    pt_x_q     <= x_read_data;
                    pt_y_q     <= y_read_data;
                    pt_index_q <= idx_q;
                    pt_last_q  <= (idx_q == size_q - 8'd1);
                    pt_valid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: if (pt_ready) begin
                    pt_valid_q <= 1'b0;
                    if (pt_last_q) state_q <= FIN;
                    else begin
                        idx_q   <= idx_q + 8'd1;
                        state_q <= READ;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xy_point_reader.sv
// tb_xy_point_reader: scoreboard bench for xy_point_reader with an M10K read model.
module tb_xy_point_reader;
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  idx;
        logic        last;
    } pt_t;

    logic        clk = 0, reset = 1, start = 0, pt_ready = 1;
    logic [7:0]  arr_size = 0;
    logic [7:0]  x_read_addr, y_read_addr, pt_index;
    logic [31:0] x_read_data, y_read_data, pt_x, pt_y;
    logic        pt_valid, pt_last, busy, done;
    logic [31:0] xm [256];
    logic [31:0] ym [256];
    pt_t         sb [$];
    int          checks = 0, errors = 0, done_cnt = 0, addr_diff = 0;
    bit          hit255 = 0;

    xy_point_reader dut (
        .clk(clk), .reset(reset), .start(start), .arr_size(arr_size),
        .x_read_addr(x_read_addr), .y_read_addr(y_read_addr),
        .x_read_data(x_read_data), .y_read_data(y_read_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
        .pt_index(pt_index), .pt_last(pt_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_read_data <= xm[x_read_addr];
        y_read_data <= ym[y_read_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (x_read_addr == 8'hFF) hit255 = 1;
            if (x_read_addr != y_read_addr) addr_diff++;
            if (done) done_cnt++;
            if (pt_valid && pt_ready) begin
                if (sb.size() == 0) chk("unexpected_point", {56'd0, pt_index}, 64'hFFFF);
                else begin
                    pt_t e;
                    e = sb.pop_front();
                    chk("pt_x", pt_x, e.x);
                    chk("pt_y", pt_y, e.y);
                    chk("pt_index", pt_index, e.idx);
                    chk("pt_last", pt_last, e.last);
                end
            end
        end
    end

    task automatic load4();
        xm[0] = 32'd10;  xm[1] = -32'sd5; xm[2] = 32'd7;    xm[3] = 32'd100;
        ym[0] = 32'd20;  ym[1] = 32'd30;  ym[2] = -32'sd1;  ym[3] = 32'd0;
    endtask

    task automatic run(input int n, input int stall_idx, input int restart_at, input string nm);
        int cyc = 0, bz = 0, st = 0, d0, extra;
        bit got = 0;
        extra = (stall_idx >= 0) ? 5 : 0;
        for (int i = 0; i < n; i++) sb.push_back('{xm[i], ym[i], 8'(i), (i == n - 1)});
        d0 = done_cnt;
        arr_size = 8'(n);
        start = 1;
        pt_ready = 1;
        @(posedge clk); #1;
        start = 0;
        arr_size = 8'd77;
        while (!got && cyc < 3 * n + 60) begin
            cyc++;
            if (busy) bz++;
            if (done) got = 1;
            else begin
                if (cyc == restart_at) begin
                    start = 1;
                    arr_size = 8'd2;
                end else start = 0;
                if (pt_valid && int'(pt_index) == stall_idx && st < 5) begin
                    pt_ready = 0;
                    st++;
                    chk({nm, " stall_x"}, pt_x, xm[stall_idx]);
                    chk({nm, " stall_y"}, pt_y, ym[stall_idx]);
                end else pt_ready = 1;
                @(posedge clk); #1;
            end
        end
        chk({nm, " done_seen"}, got, 1);
        chk({nm, " done_latency"}, cyc, 3 * n + 2 + extra);
        chk({nm, " busy_cycles"}, bz, 3 * n + 1 + extra);
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, done, 0);
        chk({nm, " done_count"}, done_cnt - d0, 1);
        chk({nm, " sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int d0, w;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w;
        for (int i = 0; i < 256; i++) begin
            xm[i] = 32'(i * 7) - 32'd300;
            ym[i] = ~32'(i);
        end
        load4();
        repeat (2) @(posedge clk);
        #1;
        chk("rst pt_valid", pt_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pt_last", pt_last, 0);
        chk("rst pt_x", pt_x, 0);
        chk("rst pt_y", pt_y, 0);
        chk("rst pt_index", pt_index, 0);
        chk("rst x_addr", x_read_addr, 0);
        chk("rst y_addr", y_read_addr, 0);
        reset = 0;
        @(posedge clk); #1;

        run(4, -1, -1, "basic");
        run(4, 1, -1, "stall");
        run(0, -1, -1, "empty");
        for (int i = 0; i < 4; i++) begin
            xm[i] = 32'(i * 7) - 32'd300;
            ym[i] = ~32'(i);
        end
        hit255 = 0;
        run(255, -1, -1, "full");
        chk("full addr255_seen", hit255, 0);
        load4();
        run(4, -1, 5, "restart");

        arr_size = 8'd4;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        pt_ready = 0;
        w = 0;
        while (!pt_valid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("abort valid_before", pt_valid, 1);
        d0 = done_cnt;
        #2 reset = 1;
        #1;
        chk("abort valid_async", pt_valid, 0);
        chk("abort busy_async", busy, 0);
        chk("abort addr_async", x_read_addr, 0);
        @(posedge clk); #1;
        reset = 0;
        pt_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no_done", done_cnt - d0, 0);
        chk("abort no_valid", pt_valid, 0);
        run(2, -1, -1, "after_reset");
        chk("addr_xy_equal", addr_diff, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
